// File: rtl/fp_pkg.sv
// Shared constants and helpers for the parametrizable FP datapath.
// Packed float width, position width of the leading-one detector, E4M3 format test.
// Combinational helpers only; no storage.
package fp_pkg;

  // Packed float width: sign + exponent + stored mantissa.
  function automatic int fp_fw(input int exp_w, input int man_w);
    return exp_w + man_w + 1;
  endfunction

  // Width of an index into an n-bit vector.
  function automatic int fp_pos_w(input int n);
    return $clog2(n);
  endfunction

  // E4M3 has no infinity and a single NaN mantissa pattern per sign.
  function automatic bit is_e4m3(input int exp_w, input int man_w);
    return (exp_w == 4) && (man_w == 3);
  endfunction

endpackage

// File: rtl/is_special_float.sv
// Classifies one packed float as zero, infinity, quiet NaN or signaling NaN.
// Latency 0 (purely combinational).
// No flow control; outputs follow float_in.
module is_special_float
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  localparam int FW = fp_fw(EXPONENT_WIDTH, MANTISSA_WIDTH)
) (
  input  logic [FW-1:0] float_in,
  output logic          is_zero,
  output logic          is_infinite,
  output logic          is_quiet_nan,
  output logic          is_signaling_nan
);

  logic [EXPONENT_WIDTH-1:0] w_exp;
  logic [MANTISSA_WIDTH-1:0] w_man;
  logic                      w_exp_all1;
  logic                      w_man_zero;
  // Sign never affects the class; kept named so the whole operand is visibly consumed.
  logic                      w_unused_sign;

  assign w_exp         = float_in[FW-2 -: EXPONENT_WIDTH];
  assign w_man         = float_in[MANTISSA_WIDTH-1:0];
  assign w_unused_sign = float_in[FW-1];
  assign w_exp_all1    = &w_exp;
  assign w_man_zero    = (w_man == '0);

  // Denormals (exp==0, man!=0) are deliberately not zero.
  assign is_zero = (w_exp == '0) && w_man_zero;

  generate
    if (is_e4m3(EXPONENT_WIDTH, MANTISSA_WIDTH)) begin : g_e4m3
      // Only S.1111.111 is NaN; other all-ones-exponent codes are ordinary normals.
      assign is_infinite      = 1'b0;
      assign is_quiet_nan     = w_exp_all1 && (&w_man);
      assign is_signaling_nan = 1'b0;
    end else begin : g_ieee
      // Mantissa MSB separates quiet from signaling NaN.
      assign is_infinite      = w_exp_all1 && w_man_zero;
      assign is_quiet_nan     = w_exp_all1 && w_man[MANTISSA_WIDTH-1];
      assign is_signaling_nan = w_exp_all1 && !w_man[MANTISSA_WIDTH-1] && !w_man_zero;
    end
  endgenerate

endmodule

// File: rtl/leading_one_detector.sv
// Priority encoder: index of the most significant set bit of lod_in.
// Latency 0 (purely combinational).
// No flow control; position is 0 when lod_in is 0, qualify with has_leading_one.
module leading_one_detector
  import fp_pkg::*;
#(
  parameter int LOD_WIDTH = 28,
  localparam int PW = fp_pos_w(LOD_WIDTH)
) (
  input  logic [LOD_WIDTH-1:0] lod_in,
  output logic [PW-1:0]        position,
  output logic                 has_leading_one
);

  assign has_leading_one = |lod_in;

  // Scan LSB to MSB so the highest set bit is the last one written.
  always_comb begin
    position = '0;
    for (int i = 0; i < LOD_WIDTH; i++) begin
      if (lod_in[i]) position = PW'(i);
    end
  end

endmodule

// File: rtl/float_special_lod_unit.sv
// Registered float classification plus leading-one detection on an independent vector.
// Latency 1 cycle; out_valid mirrors in_valid, data registers load only on in_valid.
// No backpressure: a new operand may be accepted every cycle.
module float_special_lod_unit
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int LOD_WIDTH      = MANTISSA_WIDTH + 2 + 3,
  localparam int FW = fp_fw(EXPONENT_WIDTH, MANTISSA_WIDTH),
  localparam int PW = fp_pos_w(LOD_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [FW-1:0]        float_in,
  input  logic [LOD_WIDTH-1:0] lod_in,
  output logic                 out_valid,
  output logic                 is_zero,
  output logic                 is_infinite,
  output logic                 is_quiet_nan,
  output logic                 is_signaling_nan,
  output logic [PW-1:0]        position,
  output logic                 has_leading_one
);

  logic          w_zero;
  logic          w_inf;
  logic          w_qnan;
  logic          w_snan;
  logic [PW-1:0] w_pos;
  logic          w_has_one;

  logic          r_valid;
  logic          r_zero;
  logic          r_inf;
  logic          r_qnan;
  logic          r_snan;
  logic [PW-1:0] r_pos;
  logic          r_has_one;

  is_special_float #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_classify (
    .float_in        (float_in),
    .is_zero         (w_zero),
    .is_infinite     (w_inf),
    .is_quiet_nan    (w_qnan),
    .is_signaling_nan(w_snan)
  );

  leading_one_detector #(
    .LOD_WIDTH(LOD_WIDTH)
  ) u_lod (
    .lod_in         (lod_in),
    .position       (w_pos),
    .has_leading_one(w_has_one)
  );

  // Valid tracks the input every cycle; data holds the last accepted operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_zero    <= 1'b0;
      r_inf     <= 1'b0;
      r_qnan    <= 1'b0;
      r_snan    <= 1'b0;
      r_pos     <= '0;
      r_has_one <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_zero    <= w_zero;
        r_inf     <= w_inf;
        r_qnan    <= w_qnan;
        r_snan    <= w_snan;
        r_pos     <= w_pos;
        r_has_one <= w_has_one;
      end
    end
  end

  assign out_valid        = r_valid;
  assign is_zero          = r_zero;
  assign is_infinite      = r_inf;
  assign is_quiet_nan     = r_qnan;
  assign is_signaling_nan = r_snan;
  assign position         = r_pos;
  assign has_leading_one  = r_has_one;

endmodule

// File: tb/tb_float_special_lod_unit.sv
// Scoreboard bench for float_special_lod_unit: FP32 instance plus an E4M3 instance.
// Stimulus pushes expected {flags,position,has_one}; a negedge monitor pops on out_valid.
// Reset and hold behaviour are checked directly against zero / last captured values.
module tb_float_special_lod_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FP32 instance
  logic        a_vi = 1'b0;
  logic [31:0] a_f  = '0;
  logic [27:0] a_l  = '0;
  logic        a_vo, a_z, a_inf, a_qn, a_sn, a_h;
  logic [4:0]  a_pos;

  // E4M3 instance
  logic        b_vi = 1'b0;
  logic [7:0]  b_f  = '0;
  logic [7:0]  b_l  = '0;
  logic        b_vo, b_z, b_inf, b_qn, b_sn, b_h;
  logic [2:0]  b_pos;

  float_special_lod_unit u_dut32 (
    .clk(clk), .rst(rst), .in_valid(a_vi), .float_in(a_f), .lod_in(a_l),
    .out_valid(a_vo), .is_zero(a_z), .is_infinite(a_inf), .is_quiet_nan(a_qn),
    .is_signaling_nan(a_sn), .position(a_pos), .has_leading_one(a_h)
  );

  float_special_lod_unit #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(b_vi), .float_in(b_f), .lod_in(b_l),
    .out_valid(b_vo), .is_zero(b_z), .is_infinite(b_inf), .is_quiet_nan(b_qn),
    .is_signaling_nan(b_sn), .position(b_pos), .has_leading_one(b_h)
  );

  // expected = {zero, inf, qnan, snan, position, has_one}
  logic [9:0] q32[$];
  logic [7:0] q8[$];

  function automatic logic [9:0] got32();
    return {a_z, a_inf, a_qn, a_sn, a_pos, a_h};
  endfunction

  function automatic logic [7:0] got8();
    return {b_z, b_inf, b_qn, b_sn, b_pos, b_h};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: compare each presented result with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && a_vo) begin
      if (q32.size() == 0) check("fp32_unexpected_valid", 16'd1, 16'd0);
      else check("fp32_result", {6'd0, got32()}, {6'd0, q32.pop_front()});
    end
    if (!rst && b_vo) begin
      if (q8.size() == 0) check("e4m3_unexpected_valid", 16'd1, 16'd0);
      else check("e4m3_result", {8'd0, got8()}, {8'd0, q8.pop_front()});
    end
  end

  task automatic send32(input logic [31:0] f, input logic [27:0] l,
                        input logic [3:0] flags, input logic [4:0] pos, input logic h);
    @(posedge clk); #1;
    a_vi = 1'b1; a_f = f; a_l = l;
    q32.push_back({flags, pos, h});
  endtask

  task automatic send8(input logic [7:0] f, input logic [7:0] l,
                       input logic [3:0] flags, input logic [2:0] pos, input logic h);
    @(posedge clk); #1;
    b_vi = 1'b1; b_f = f; b_l = l;
    q8.push_back({flags, pos, h});
  endtask

  // Flags order: {zero, inf, qnan, snan}
  initial begin
    logic [9:0] last32;
    repeat (3) @(posedge clk);
    #1;
    check("reset_fp32", {5'd0, a_vo, got32()}, 16'd0);
    check("reset_e4m3", {7'd0, b_vo, got8()}, 16'd0);
    rst = 1'b0;

    // Mid-stream reset: captured result must vanish at once.
    send32(32'h7F800000, 28'h8000000, 4'b0100, 5'd27, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1; a_vi = 1'b0;
    #1;
    check("midreset_clear", {5'd0, a_vo, got32()}, 16'd0);
    q32.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_release_hold0", {5'd0, a_vo, got32()}, 16'd0);

    // FP32 classification and leading-one vectors
    send32(32'h7F800000, 28'h8000000, 4'b0100, 5'd27, 1'b1);
    send32(32'hFF800000, 28'h0C00000, 4'b0100, 5'd23, 1'b1);
    send32(32'h80000000, 28'h0000001, 4'b1000, 5'd0,  1'b1);
    send32(32'h00000001, 28'h0000000, 4'b0000, 5'd0,  1'b0);
    send32(32'h7FC00000, 28'h0000100, 4'b0010, 5'd8,  1'b1);
    send32(32'h7F800001, 28'h0F0F0F0, 4'b0001, 5'd23, 1'b1);
    send32(32'h7F7FFFFF, 28'hFFFFFFF, 4'b0000, 5'd27, 1'b1);
    send32(32'hFFFFFFFF, 28'h0000002, 4'b0010, 5'd1,  1'b1);
    last32 = {4'b0010, 5'd1, 1'b1};

    // Idle with changing inputs: data holds, valid low.
    @(posedge clk); #1;
    a_vi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a_f = 32'h7F800000 + i; a_l = 28'h0000010 << i;
      @(negedge clk);
      check("idle_valid_low", {15'd0, a_vo}, 16'd0);
      check("idle_hold", {6'd0, got32()}, {6'd0, last32});
    end
  end

  initial begin
    @(negedge rst);
    @(negedge rst);
    repeat (4) @(posedge clk);
    send8(8'h7F, 8'h10, 4'b0010, 3'd4, 1'b1);
    send8(8'hFF, 8'h80, 4'b0010, 3'd7, 1'b1);
    send8(8'h78, 8'h01, 4'b0000, 3'd0, 1'b1);
    send8(8'h00, 8'h00, 4'b1000, 3'd0, 1'b0);
    send8(8'h08, 8'h06, 4'b0000, 3'd2, 1'b1);
    @(posedge clk); #1;
    b_vi = 1'b0;
  end

  // End of run: drain both scoreboards within a bounded time.
  initial begin
    int waited;
    #600;
    waited = 0;
    while ((q32.size() != 0 || q8.size() != 0) && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    check("scoreboard_drained", 16'(q32.size() + q8.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
